// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: EXU request, WBU response and AXI4-Lite data-port signals of the LSU.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid, in_ready, in_wen;
    logic [2:0]        in_func3;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic              out_valid, out_ready, out_err;
    logic [31:0]       out_rdata;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              arvalid, arready, rvalid, rready;

    modport master (
        input  in_valid, in_wen, in_func3, in_addr, in_wdata, out_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output in_ready, out_valid, out_rdata, out_err,
               awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready
    );

    modport slave (
        output in_valid, in_wen, in_func3, in_addr, in_wdata, out_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  in_ready, out_valid, out_rdata, out_err,
               awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store sequencer onto an AXI4-Lite data port.
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic            clock,
    input logic            reset,
    lsu_mem_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        func3;
    logic [31:0]       wdata, rdata, fmt_wdata, ext_rdata;
    logic [3:0]        wstrb, fmt_wstrb;
    logic              err, aw_done, w_done, bad, misaligned, accept, aw_hs, w_hs;
    logic [1:0]        off;
    logic [7:0]        lb;
    logic [15:0]       lh;

    assign off        = bus.in_addr[1:0];
    assign accept     = state == IDLE && bus.in_valid;
    assign bad        = (bus.in_func3[1:0] == 2'b11) | (bus.in_wen ? bus.in_func3[2] : bus.in_func3 == 3'b110);
    assign misaligned = CHECK_ALIGN && ((bus.in_func3[1:0] == 2'b01 && off[0]) ||
                                        (bus.in_func3[1:0] == 2'b10 && off != 2'b00));
    assign fmt_wdata  = bus.in_func3[1:0] == 2'b00 ? {24'b0, bus.in_wdata[7:0]} << {off, 3'b0} :
                        bus.in_func3[1:0] == 2'b01 ? {16'b0, bus.in_wdata[15:0]} << {off[1], 4'b0} :
                        bus.in_wdata;
    assign fmt_wstrb  = bus.in_func3[1:0] == 2'b00 ? 4'b0001 << off :
                        bus.in_func3[1:0] == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;

    // Lane select uses the latched address; func3[2] distinguishes zero- from sign-extension.
    assign lb        = 8'(bus.rdata >> {addr[1:0], 3'b0});
    assign lh        = 16'(bus.rdata >> {addr[1], 4'b0});
    assign ext_rdata = func3[1:0] == 2'b00 ? {{24{~func3[2] & lb[7]}}, lb} :
                       func3[1:0] == 2'b01 ? {{16{~func3[2] & lh[15]}}, lh} : bus.rdata;

    assign bus.in_ready  = state == IDLE;
    assign bus.awvalid   = state == WRITE && !aw_done;
    assign bus.wvalid    = state == WRITE && !w_done;
    assign bus.bready    = state == WRESP;
    assign bus.arvalid   = state == READ;
    assign bus.rready    = state == RDATA;
    assign bus.out_valid = state == RESP;
    assign bus.out_rdata = rdata;
    assign bus.out_err   = err;
    assign bus.awaddr    = addr;
    assign bus.araddr    = addr;
    assign bus.wdata     = wdata;
    assign bus.wstrb     = wstrb;
    assign aw_hs         = bus.awvalid && bus.awready;
    assign w_hs          = bus.wvalid && bus.wready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = (bad || misaligned) ? RESP : bus.in_wen ? WRITE : READ;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WRESP;
            WRESP:   if (bus.bvalid) state_nx = RESP;
            READ:    if (bus.arready) state_nx = RDATA;
            RDATA:   if (bus.rvalid) state_nx = RESP;
            RESP:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            func3   <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr    <= bus.in_addr;
                func3   <= bus.in_func3;
                wdata   <= fmt_wdata;
                wstrb   <= fmt_wstrb;
                rdata   <= '0;
                err     <= bad || misaligned;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == WRESP && bus.bvalid) err <= |bus.bresp;
            if (state == RDATA && bus.rvalid) begin
                rdata <= ext_rdata;
                err   <= |bus.rresp;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed plus randomized requests against an AXI4-Lite slave model,
// with expected results derived from access size/offset arithmetic.
module tb_lsu_mem_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
    lsu_mem_ctrl #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Slave: mode 0 zero-wait, 1 random waits, 2 wready late after AW, 3 stalled.
    int          mode = 0;
    logic [1:0]  resp_val = 2'b00;
    logic [31:0] rd_val = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, dly = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        aw_seen, w_seen, ar_seen, go;
    logic        aw_hs, w_hs, ar_hs;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.arready <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
            aw_seen     <= 1'b0;
            w_seen      <= 1'b0;
            ar_seen     <= 1'b0;
            dly         <= 0;
        end else begin
            go = mode != 1 || $urandom_range(1, 0) == 1;
            bus.awready <= mode == 0 || mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1);
            bus.arready <= mode == 0 || mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1);
            bus.wready  <= mode == 0 || (mode == 2 && aw_seen && dly >= 3) || (mode == 1 && $urandom_range(1, 0) == 1);
            dly <= aw_hs ? 0 : (dly < 100 ? dly + 1 : dly);
            if (aw_hs) begin
                aw_cnt     <= aw_cnt + 1;
                cap_awaddr <= bus.awaddr;
            end
            if (w_hs) begin
                w_cnt     <= w_cnt + 1;
                cap_wdata <= bus.wdata;
                cap_wstrb <= bus.wstrb;
            end
            if (ar_hs) begin
                ar_cnt     <= ar_cnt + 1;
                cap_araddr <= bus.araddr;
            end
            aw_seen <= aw_seen | aw_hs;
            w_seen  <= w_seen | w_hs;
            ar_seen <= ar_seen | ar_hs;
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (!bus.bvalid && (aw_seen | aw_hs) && (w_seen | w_hs) && go) begin
                bus.bvalid <= 1'b1;
                bus.bresp  <= resp_val;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (!bus.rvalid && (ar_seen | ar_hs) && go) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= rd_val;
                bus.rresp  <= resp_val;
                ar_seen    <= 1'b0;
            end
        end
    end

    // One request end to end; exp_lat > 0 also checks accept-to-out_valid cycles.
    task automatic run(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, input int exp_lat);
        int a0, w0, r0, off, size, cyc;
        longint mask, v;
        bit ok, early, busy_rdy;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0] exp_strb;
        logic exp_err;
        a0 = aw_cnt;
        w0 = w_cnt;
        r0 = ar_cnt;
        off  = int'(addr % 4);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        ok   = wen ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        ok   = ok && (off % size == 0);
        mask = (longint'(1) << (8 * size)) - 1;
        exp_strb = 4'(((1 << size) - 1) << off);
        exp_wd   = 32'((longint'(wd) & mask) << (8 * off));
        v = (longint'(rd_val) >> (8 * off)) & mask;
        if (f3 < 4 && size < 4 && v > mask / 2) v = v - (mask + 1);
        exp_rd  = (ok && !wen) ? 32'(v) : 32'h0;
        exp_err = !ok || resp_val != 2'b00;
        @(negedge clock);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_wen   = wen;
        bus.in_func3 = f3;
        bus.in_addr  = addr;
        bus.in_wdata = wd;
        @(negedge clock);
        bus.in_wen   = ~wen;
        bus.in_func3 = 3'($urandom_range(7, 0));
        bus.in_addr  = $urandom;
        bus.in_wdata = $urandom;
        cyc = 1;
        early = 0;
        busy_rdy = 0;
        while (!bus.out_valid && cyc < 200) begin
            busy_rdy |= bus.in_ready;
            if (bus.bready && w_cnt == w0) early = 1;
            @(negedge clock);
            cyc++;
        end
        check("out_valid", bus.out_valid, 1);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        check("out_rdata", bus.out_rdata, exp_rd);
        check("out_err", bus.out_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            busy_rdy |= bus.in_ready;
            @(negedge clock);
            check("hold_valid", bus.out_valid, 1);
            check("hold_rdata", bus.out_rdata, exp_rd);
            check("hold_err", bus.out_err, exp_err);
        end
        busy_rdy |= bus.in_ready;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
        check("busy_in_ready", busy_rdy, 0);
        check("aw_beats", aw_cnt - a0, (ok && wen) ? 1 : 0);
        check("w_beats", w_cnt - w0, (ok && wen) ? 1 : 0);
        check("ar_beats", ar_cnt - r0, (ok && !wen) ? 1 : 0);
        if (ok && wen) begin
            check("awaddr", cap_awaddr, addr);
            check("wdata", cap_wdata, exp_wd);
            check("wstrb", cap_wstrb, exp_strb);
            check("wresp_order", early, 0);
        end
        if (ok && !wen) check("araddr", cap_araddr, addr);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_wen    = 1'b0;
        bus.in_func3  = '0;
        bus.in_addr   = '0;
        bus.in_wdata  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_out_rdata", bus.out_rdata, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_awaddr", bus.awaddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_wstrb", bus.wstrb, 0);
        reset = 1'b0;

        mode = 0;
        run(1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 0, 3);
        check("sb_wdata_plan", cap_wdata, 32'hAB00_0000);
        check("sb_wstrb_plan", cap_wstrb, 4'b1000);
        mode = 2;
        run(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 0);
        check("sh_wdata_plan", cap_wdata, 32'hBEEF_0000);
        check("sh_wstrb_plan", cap_wstrb, 4'b1100);
        mode = 0;
        rd_val = 32'h0000_8000;
        run(1'b0, 3'b000, 32'h8000_0001, 32'h0, 0, 3);
        check("lb_plan", bus.out_rdata, 32'hFFFF_FF80);
        run(1'b0, 3'b100, 32'h8000_0001, 32'h0, 0, 3);
        rd_val = 32'hF00D_0000;
        run(1'b0, 3'b101, 32'h8000_0002, 32'h0, 0, 3);
        run(1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, 0);
        resp_val = 2'b10;
        run(1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 0, 3);
        resp_val = 2'b00;
        rd_val = 32'h1357_9BDF;
        run(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5, 3);

        mode = 3;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_wen   = 1'b1;
        bus.in_func3 = 3'b010;
        bus.in_addr  = 32'h8000_0020;
        bus.in_wdata = 32'h0BAD_F00D;
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.awvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("awvalid_pre_reset", bus.awvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("reset_awvalid", bus.awvalid, 0);
        check("reset_wvalid", bus.wvalid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        mode = 0;
        run(1'b1, 3'b010, 32'h8000_0024, 32'hCAFE_F00D, 0, 3);

        mode = 1;
        for (int i = 0; i < 150; i++) begin
            resp_val = ($urandom_range(4, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            rd_val = $urandom;
            run(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), $urandom, $urandom,
                $urandom_range(3, 0), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the EXU memory stage and the AXI4-Lite data port of the NPC core. It accepts one memory request at a time and formats store data and byte strobes from func3 and address offset. It drives the AW/W/B or AR/R channel handshakes, then extracts and sign/zero-extends load data. The result goes back to the WBU over a valid/ready pair.

Parameters:
ADDR_W, 32, address width of request and AXI address channels
CHECK_ALIGN, 1, 1 = misaligned accesses are rejected locally with error; 0 = issued as-is

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid from EXU
in_ready  out  1  block can accept request
in_wen  in  1  1 = store, 0 = load
in_func3  in  3  RV32I funct3 (SB/SH/SW, LB/LH/LW/LBU/LHU)
in_addr  in  ADDR_W  byte address
in_wdata  in  32  unformatted store data (rs2)
out_valid  out  1  response valid to WBU
out_ready  in  1  WBU accepts response
out_rdata  out  32  extended load data (0 for stores)
out_err  out  1  bus error or misalignment
awvalid/awready  out/in  1  write address handshake
awaddr  out  ADDR_W  write byte address
wvalid/wready  out/in  1  write data handshake
wdata  out  32  lane-shifted store data
wstrb  out  4  byte strobes
bvalid/bready  in/out  1  write response handshake
bresp  in  2  write response (nonzero = error)
arvalid/arready  out/in  1  read address handshake
araddr  out  ADDR_W  read byte address
rvalid/rready  in/out  1  read data handshake
rdata  in  32  read word
rresp  in  2  read response (nonzero = error)

Behaviour:
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP. Reset → IDLE. All valids/readies are 0 except in_ready=1. out_rdata, out_err, and all address/data/strobe registers are 0.
- IDLE: in_ready=1. On in_valid, latch addr, func3, wen, and formatted wdata/wstrb:
  - SB: data byte shifted to lane addr[1:0], strobe 0001<<addr[1:0].
  - SH: halfword at lane addr[1]*2, strobe 0011<<(addr[1]*2).
  - SW: full word, strobe 1111.
  - Next state is WRITE for stores, READ for loads.
- Misaligned access (CHECK_ALIGN=1): SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]≠0. No bus traffic; go directly to RESP with out_err=1 and out_rdata=0.
- Invalid func3 (store 011–111; load 011, 110, 111): treated as error, same as misaligned.
- WRITE: awvalid and wvalid assert in the cycle after acceptance.
  - Each deasserts independently after its own handshake; the two may complete in either order or the same cycle.
  - Once both have completed → WRESP.
  - awaddr/wdata/wstrb are held stable while the corresponding valid is high.
- WRESP: bready=1. On bvalid → RESP, out_err = (bresp≠0).
- READ: arvalid=1 until arready → RDATA.
- RDATA: rready=1. On rvalid, select the lane by addr[1:0] and extend:
  - LB/LBU: byte, sign-/zero-extended.
  - LH/LHU: halfword at addr[1], sign-/zero-extended.
  - LW: full word.
  - Capture into out_rdata, set out_err = (rresp≠0), go to RESP.
- RESP: out_valid=1 holding stable values until out_ready; then → IDLE. The next request is accepted no earlier than the following cycle, so there is no back-to-back bypass.
- Minimum latency with zero-wait slave: store = 3 cycles accept→out_valid; load = 3 cycles.
- in_ready=0 in every state but IDLE. No outstanding transactions beyond one.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops all valids. The in-flight bus transaction is abandoned; the slave is reset in the same domain.

Test Plan:
- SB addr 0x8000_0003, wdata 0x1234_56AB, zero-wait slave → awaddr 0x8000_0003, wdata 0xAB00_0000, wstrb 1000; out_valid 3 cycles after accept, out_err=0.
- SH addr 0x...2, wdata 0x0000_BEEF; wready delayed 4 cycles after awready → wdata 0xBEEF_0000, wstrb 1100; WRESP entered only after W handshake; one AW and one W beat.
- LB addr 0x...1, rdata 0x0000_8000 → out_rdata 0xFFFF_FF80. Same with LBU → 0x0000_0080. LHU addr 0x...2, rdata 0xF00D_0000 → 0x0000_F00D.
- LW addr 0x...2 (misaligned) → no arvalid ever; out_valid with out_err=1, out_rdata=0. SW with bresp=2'b10 → out_err=1.
- out_ready held low 5 cycles in RESP → out_valid/out_rdata stable, in_ready=0; a new in_valid is ignored until IDLE.
- Assert reset while awvalid=1 → awvalid/wvalid drop asynchronously, state IDLE, in_ready=1 after release; the next SW completes normally.
